// File: rtl/cordiv_sched_pkg.sv
// Shared types and LFSR helpers for the CORDIV divider scheduler.
package cordiv_sched_pkg;

  typedef enum logic [1:0] {IDLE, WARM, RUN, RESP} state_t;

  localparam int unsigned LFSR_MAX_W = 16;

  // Maximal-length Fibonacci tap masks, bit n-1 set for polynomial term x^n.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_taps(input int unsigned bw);
    logic [LFSR_MAX_W-1:0] taps;
    taps = '0;
    case (bw)
      4:       taps = 16'h000C;
      5:       taps = 16'h0014;
      6:       taps = 16'h0030;
      7:       taps = 16'h0060;
      8:       taps = 16'h00B8;
      9:       taps = 16'h0110;
      10:      taps = 16'h0240;
      11:      taps = 16'h0500;
      12:      taps = 16'h0829;
      13:      taps = 16'h100D;
      14:      taps = 16'h2015;
      15:      taps = 16'h6000;
      16:      taps = 16'hD008;
      default: taps = '0;
    endcase
    return taps;
  endfunction

  function automatic logic [LFSR_MAX_W-1:0] lfsr_next(input logic [LFSR_MAX_W-1:0] st,
                                                      input int unsigned bw);
    logic [LFSR_MAX_W-1:0] mask;
    logic                  fb;
    mask = 16'((32'd1 << bw) - 32'd1);
    fb   = ^(st & lfsr_taps(bw));
    return ((st << 1) | {15'd0, fb}) & mask;
  endfunction

endpackage

// File: rtl/cordiv_sched_rr_arb.sv
// Combinational round-robin pick: first valid index at or after ptr, wrapping.
module cordiv_sched_rr_arb #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant_c,
  output logic [IW-1:0]   idx_c,
  output logic            any_c
);

  int unsigned cand;

  always_comb begin
    grant_c = '0;
    idx_c   = '0;
    any_c   = 1'b0;
    cand    = 0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      cand = (32'(ptr) + off) % NREQ;
      if (!any_c && valid[cand[IW-1:0]]) begin
        any_c                  = 1'b1;
        grant_c[cand[IW-1:0]]  = 1'b1;
        idx_c                  = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/cordiv_is_b_sched.sv
// Time-shares one bipolar in-stream CORDIV divider among NREQ requesters and
// returns the quotient ones count over a fixed window.
module cordiv_is_b_sched #(
  parameter int unsigned   BW   = 8,
  parameter int unsigned   NREQ = 4,
  parameter int unsigned   WARM = 32,
  parameter int unsigned   LEN  = 256,
  parameter logic [BW-1:0] SEED = BW'(1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*BW-1:0]      req_a,
  input  logic [NREQ*BW-1:0]      req_b,
  output logic [BW-1:0]           k_rand,
  output logic                    k_dividend,
  output logic                    k_divisor,
  input  logic                    k_quotient,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [BW:0]             rsp_ones,
  output logic                    busy
);

  import cordiv_sched_pkg::state_t;
  import cordiv_sched_pkg::IDLE;
  import cordiv_sched_pkg::RUN;
  import cordiv_sched_pkg::RESP;
  import cordiv_sched_pkg::lfsr_next;

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned CW = BW + 1;
  localparam int unsigned PW = $clog2(((WARM > LEN) ? WARM : LEN) + 1);

  state_t          state, state_nxt;
  logic [BW-1:0]   lfsr, a_reg, b_reg;
  logic [IW-1:0]   id_reg, ptr;
  logic            toggle;
  logic [PW-1:0]   phase;
  logic [CW-1:0]   count;
  logic [NREQ-1:0] grant_c;
  logic [IW-1:0]   grant_idx_c;
  logic            grant_any_c;
  logic [BW-1:0]   a_sel_c, b_sel_c;
  logic            phase_done_c, stream_c;

  cordiv_sched_rr_arb #(.NREQ(NREQ), .IW(IW)) u_arb (
    .valid   (req_valid),
    .ptr     (ptr),
    .grant_c (grant_c),
    .idx_c   (grant_idx_c),
    .any_c   (grant_any_c)
  );

  assign phase_done_c = (phase == '0);
  assign stream_c     = (state == cordiv_sched_pkg::WARM) || (state == RUN);
  assign req_ready    = (state == IDLE) ? grant_c : '0;
  assign k_rand       = lfsr;
  // Outside WARM/RUN both streams carry the same toggle so the divider stays balanced.
  assign k_dividend   = stream_c ? (a_reg > lfsr) : toggle;
  assign k_divisor    = stream_c ? (b_reg > lfsr) : toggle;

  // Operand mux for the granted requester.
  always_comb begin
    a_sel_c = '0;
    b_sel_c = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_c[i]) begin
        a_sel_c = req_a[i*BW +: BW];
        b_sel_c = req_b[i*BW +: BW];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:                    if (grant_any_c)  state_nxt = cordiv_sched_pkg::WARM;
      cordiv_sched_pkg::WARM:  if (phase_done_c) state_nxt = RUN;
      RUN:                     if (phase_done_c) state_nxt = RESP;
      RESP:                    if (rsp_ready)    state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
    end
  end

  // Datapath: LFSR, operand capture, shared phase down-counter, ones counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr      <= SEED;
      toggle    <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      id_reg    <= '0;
      ptr       <= '0;
      phase     <= '0;
      count     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_ones  <= '0;
    end else begin
      lfsr   <= BW'(lfsr_next(16'(lfsr), BW));
      toggle <= ~toggle;
      case (state)
        IDLE: begin
          if (grant_any_c) begin
            a_reg  <= a_sel_c;
            b_reg  <= b_sel_c;
            id_reg <= grant_idx_c;
            ptr    <= (grant_idx_c == IW'(NREQ - 1)) ? '0 : grant_idx_c + IW'(1);
            phase  <= PW'(WARM - 1);
          end
        end
        cordiv_sched_pkg::WARM: begin
          if (phase_done_c) begin
            phase <= PW'(LEN - 1);
            count <= '0;
          end else begin
            phase <= phase - PW'(1);
          end
        end
        RUN: begin
          count <= count + CW'(k_quotient);
          if (phase_done_c) begin
            rsp_ones  <= count + CW'(k_quotient);
            rsp_id    <= id_reg;
            rsp_valid <= 1'b1;
          end else begin
            phase <= phase - PW'(1);
          end
        end
        RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordiv_is_b_sched.sv
// Bench for cordiv_is_b_sched: an ideal bipolar divider quotient source plus a
// scoreboard of every quotient bit driven, checked against timing and counts.
module tb_cordiv_is_b_sched;

  localparam int BW   = 8;
  localparam int NREQ = 4;
  localparam int WARM = 32;
  localparam int LEN  = 256;
  localparam int OW   = BW + 1;
  localparam int LAT  = WARM + LEN + 1;
  localparam logic [BW-1:0] SEED = 8'h01;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid, req_ready;
  logic [NREQ*BW-1:0]   req_a, req_b;
  logic [BW-1:0]        k_rand;
  logic                 k_dividend, k_divisor;
  logic                 k_quotient = 1'b0;
  logic                 rsp_valid, rsp_ready;
  logic [1:0]           rsp_id;
  logic [BW:0]          rsp_ones;
  logic                 busy;

  int  n_tests = 0;
  int  n_fail  = 0;
  int  cyc     = 0;
  bit  qhist [65536];
  real q_p     = 0.0;
  real q_acc   = 0.0;

  cordiv_is_b_sched #(.BW(BW), .NREQ(NREQ), .WARM(WARM), .LEN(LEN), .SEED(SEED)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .k_rand     (k_rand),
    .k_dividend (k_dividend),
    .k_divisor  (k_divisor),
    .k_quotient (k_quotient),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_ones   (rsp_ones),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Ideal divider: ones density (q+1)/2 via error diffusion; every bit recorded per cycle.
  always @(posedge clk) begin
    #1;
    q_acc = q_acc + q_p;
    if (q_acc >= 1.0) begin
      k_quotient = 1'b1;
      q_acc = q_acc - 1.0;
    end else begin
      k_quotient = 1'b0;
    end
    qhist[cyc % 65536] = k_quotient;
  end

  function automatic real ideal_p(input logic [BW-1:0] a, input logic [BW-1:0] b);
    real va, vb, q;
    va = 2.0 * real'(a) / 256.0 - 1.0;
    vb = 2.0 * real'(b) / 256.0 - 1.0;
    if (vb == 0.0) q = (va >= 0.0) ? 1.0 : -1.0;
    else           q = va / vb;
    if (q > 1.0)  q = 1.0;
    if (q < -1.0) q = -1.0;
    return (q + 1.0) / 2.0;
  endfunction

  function automatic int window_ones(input int t);
    int s;
    s = 0;
    for (int c = t + WARM + 1; c <= t + WARM + LEN; c++) s += int'(qhist[c % 65536]);
    return s;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_grant(input int id, input logic [BW-1:0] a, input logic [BW-1:0] b,
                          input int bound, output int t);
    logic [NREQ-1:0] exp_g;
    int k;
    exp_g = NREQ'(1) << id;
    req_a[id*BW +: BW] = a;
    req_b[id*BW +: BW] = b;
    req_valid[id] = 1'b1;
    #1;
    k = 0;
    while (req_ready == '0 && k < bound) begin
      tick();
      k++;
    end
    t = cyc;
    n_tests++;
    if (req_ready !== exp_g) begin
      n_fail++;
      $display("FAIL grant: req_ready=%b expected %b", req_ready, exp_g);
    end
    q_p   = ideal_p(a, b);
    q_acc = real'($urandom_range(0, 999)) / 1000.0;
    tick();
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_rsp(input int t, input int id, input logic [BW-1:0] a,
                          input logic [BW-1:0] b, output int ones);
    int k, errs, exp_ones;
    k = 0;
    errs = 0;
    while (rsp_valid !== 1'b1 && k < LAT + 20) begin
      if (cyc > t && cyc < t + LAT) begin
        if (k_dividend !== (a > k_rand) || k_divisor !== (b > k_rand) ||
            busy !== 1'b1 || req_ready !== '0) errs++;
      end
      tick();
      k++;
    end
    ones = int'(rsp_ones);
    n_tests++;
    if (errs != 0) begin
      n_fail++;
      $display("FAIL streams: %0d bad cycles, expected 0", errs);
    end
    n_tests++;
    if (rsp_valid !== 1'b1 || cyc != t + LAT) begin
      n_fail++;
      $display("FAIL latency: rsp_valid=%b after %0d cycles, expected 1 after %0d", rsp_valid, cyc - t, LAT);
    end
    n_tests++;
    if (rsp_id !== 2'(id)) begin
      n_fail++;
      $display("FAIL rsp_id: got %0d expected %0d", rsp_id, id);
    end
    exp_ones = window_ones(t);
    n_tests++;
    if (rsp_ones !== OW'(exp_ones)) begin
      n_fail++;
      $display("FAIL rsp_ones: got %0d expected %0d", rsp_ones, exp_ones);
    end
  endtask

  task automatic ack();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    n_tests++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ack: rsp_valid=%b busy=%b expected 0 0", rsp_valid, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b0;
    repeat (3) tick();
    n_tests++;
    if (k_rand !== SEED || rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== '0) begin
      n_fail++;
      $display("FAIL reset_ctl: k_rand=%h rsp_valid=%b busy=%b req_ready=%b expected %h 0 0 0",
               k_rand, rsp_valid, busy, req_ready, SEED);
    end
    n_tests++;
    if (rsp_id !== 2'd0 || rsp_ones !== '0 || k_dividend !== 1'b0 || k_divisor !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_data: rsp_id=%0d rsp_ones=%0d k_dividend=%b k_divisor=%b expected 0 0 0 0",
               rsp_id, rsp_ones, k_dividend, k_divisor);
    end
    rst_n = 1'b1;
    tick();
    n_tests++;
    if (req_ready !== '0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_quiet: req_ready=%b busy=%b expected 0 0", req_ready, busy);
    end
  endtask

  task automatic test_lfsr();
    logic [BW-1:0] seq [300];
    bit seen [256];
    int zeros, dups, errs;
    zeros = 0; dups = 0; errs = 0;
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    for (int i = 0; i < 300; i++) begin
      seq[i] = k_rand;
      tick();
    end
    for (int i = 0; i < 300; i++) if (seq[i] == '0) zeros++;
    for (int i = 0; i < 255; i++) begin
      if (seen[seq[i]]) dups++;
      seen[seq[i]] = 1'b1;
    end
    for (int i = 0; i < 45; i++) if (seq[i+255] !== seq[i]) errs++;
    n_tests++;
    if (zeros != 0) begin
      n_fail++;
      $display("FAIL lfsr_zero: %0d zero states, expected 0", zeros);
    end
    n_tests++;
    if (dups != 0 || errs != 0) begin
      n_fail++;
      $display("FAIL lfsr_period: %0d repeats inside 255, %0d period mismatches, expected 0 0", dups, errs);
    end
  endtask

  task automatic test_single();
    int t, ones;
    do_grant(0, 8'hC0, 8'hFF, 4, t);
    wait_rsp(t, 0, 8'hC0, 8'hFF, ones);
    n_tests++;
    if (ones < 176 || ones > 208) begin
      n_fail++;
      $display("FAIL single_tol: ones=%0d expected 192+-16", ones);
    end
    ack();
  endtask

  task automatic test_sign();
    int t, ones;
    do_grant(2, 8'h40, 8'hC0, 4, t);
    wait_rsp(t, 2, 8'h40, 8'hC0, ones);
    n_tests++;
    if (ones > 16) begin
      n_fail++;
      $display("FAIL sign_neg: ones=%0d expected <=16", ones);
    end
    ack();
    do_grant(3, 8'h40, 8'h40, 4, t);
    wait_rsp(t, 3, 8'h40, 8'h40, ones);
    n_tests++;
    if (ones < 240) begin
      n_fail++;
      $display("FAIL sign_pos: ones=%0d expected >=240", ones);
    end
    ack();
  endtask

  task automatic test_backpressure();
    int t, t1, ta, ones, errs;
    logic [1:0] hold_id;
    logic [BW:0] hold_ones;
    logic prev;
    logic [BW-1:0] a1, b1;
    a1 = 8'($urandom);
    b1 = 8'($urandom);
    do_grant(2, 8'h90, 8'hE0, 4, t);
    req_a[1*BW +: BW] = a1;
    req_b[1*BW +: BW] = b1;
    req_valid[1] = 1'b1;
    wait_rsp(t, 2, 8'h90, 8'hE0, ones);
    hold_id = rsp_id;
    hold_ones = rsp_ones;
    prev = k_dividend;
    errs = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rsp_valid !== 1'b1 || rsp_id !== hold_id || rsp_ones !== hold_ones ||
          req_ready !== '0 || busy !== 1'b1) errs++;
      if (k_dividend !== k_divisor || k_dividend === prev) errs++;
      prev = k_dividend;
    end
    n_tests++;
    if (errs != 0) begin
      n_fail++;
      $display("FAIL hold: %0d bad cycles while stalled, expected 0", errs);
    end
    rsp_ready = 1'b1;
    #1;
    ta = cyc;
    n_tests++;
    if (req_ready !== '0) begin
      n_fail++;
      $display("FAIL accept_nogrant: req_ready=%b expected 0", req_ready);
    end
    tick();
    rsp_ready = 1'b0;
    n_tests++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL accept_drop: rsp_valid=%b expected 0", rsp_valid);
    end
    do_grant(1, a1, b1, 0, t1);
    n_tests++;
    if (t1 != ta + 1) begin
      n_fail++;
      $display("FAIL next_grant: grant at %0d expected %0d", t1, ta + 1);
    end
    wait_rsp(t1, 1, a1, b1, ones);
    ack();
  endtask

  task automatic test_random();
    int t, ones, id;
    logic [BW-1:0] a, b;
    for (int j = 0; j < 6; j++) begin
      id = int'($urandom_range(0, NREQ - 1));
      a = 8'($urandom);
      b = 8'($urandom);
      if (j == 0) rsp_ready = 1'b1;
      do_grant(id, a, b, 4, t);
      wait_rsp(t, id, a, b, ones);
      ack();
    end
  endtask

  task automatic test_fairness();
    logic [BW-1:0] av [NREQ];
    logic [BW-1:0] bv [NREQ];
    int k, g, t, ones;
    rst_n = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      av[i] = 8'($urandom);
      bv[i] = 8'($urandom);
      req_a[i*BW +: BW] = av[i];
      req_b[i*BW +: BW] = bv[i];
    end
    req_valid = '1;
    tick();
    rst_n = 1'b1;
    #1;
    for (int j = 0; j < 5; j++) begin
      k = 0;
      g = -1;
      while (req_ready == '0 && k < 20) begin
        tick();
        k++;
      end
      t = cyc;
      n_tests++;
      if (req_ready !== (NREQ'(1) << (j % NREQ))) begin
        n_fail++;
        $display("FAIL rr_order: job %0d req_ready=%b expected %b", j, req_ready, NREQ'(1) << (j % NREQ));
      end
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) g = i;
      if (g < 0) g = j % NREQ;
      q_p   = ideal_p(av[g], bv[g]);
      q_acc = real'($urandom_range(0, 999)) / 1000.0;
      tick();
      if (j == 4) req_valid = '0;
      wait_rsp(t, g, av[g], bv[g], ones);
      ack();
    end
  endtask

  task automatic test_mid_reset();
    int t, ones;
    logic [BW-1:0] a1, b1;
    a1 = 8'($urandom);
    b1 = 8'($urandom);
    do_grant(0, 8'hA0, 8'hF0, 4, t);
    req_a[1*BW +: BW] = a1;
    req_b[1*BW +: BW] = b1;
    req_valid[1] = 1'b1;
    repeat (WARM + 100) tick();
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || k_rand !== SEED || rsp_ones !== '0 || k_dividend !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: busy=%b rsp_valid=%b k_rand=%h rsp_ones=%0d k_dividend=%b expected 0 0 %h 0 0",
               busy, rsp_valid, k_rand, rsp_ones, k_dividend, SEED);
    end
    tick();
    rst_n = 1'b1;
    #1;
    t = cyc;
    n_tests++;
    if (req_ready !== 4'b0010 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_grant: req_ready=%b rsp_valid=%b expected 0010 0", req_ready, rsp_valid);
    end
    q_p   = ideal_p(a1, b1);
    q_acc = 0.5;
    tick();
    req_valid[1] = 1'b0;
    wait_rsp(t, 1, a1, b1, ones);
    ack();
  endtask

  initial begin
    test_reset();
    test_lfsr();
    test_single();
    test_sign();
    test_backpressure();
    test_random();
    test_fairness();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
